// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared definitions for the digit-serial BCD subtractor.
//   state_t     : controller states (idle, digit subtract, recomplement, done)
//   BCD_MAX     : largest legal BCD digit value
//   nines_comp  : 9's complement of one BCD digit
//   digit_ok    : 1 when a 4-bit value is a legal BCD digit
package bcd_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SUB    = 2'd1,
    ST_RECOMP = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle between the arithmetic unit and the BCD subtractor.
//   start          : request, honoured only while the subtractor is idle
//   a, b           : packed-BCD minuend / subtrahend, digit 0 at [3:0]
//   busy, done     : busy while computing, done is a one-cycle result strobe
//   diff, neg      : magnitude |a-b| and sign (1 when a < b)
//   invalid        : an operand digit was above 9
// master = requester side, slave = subtractor side.
interface bcd_serial_subtractor_if #(
  parameter int NDIG = 8
) ();

  logic                start;
  logic [4*NDIG-1:0]   a;
  logic [4*NDIG-1:0]   b;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   diff;
  logic                neg;
  logic                invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, invalid
  );

endinterface

// File: rtl/bcd_serial_subtractor_adder_core.sv
// Single-digit BCD adder: s_bcd/cout_bcd = a + b + cin in decimal.
//   a, b     : BCD digits (sum of a+b+cin never exceeds 19 in this design)
//   cin      : carry in
//   s_bcd    : BCD sum digit
//   cout_bcd : decimal carry out
module bcd_adder_core
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s_bcd,
  output logic       cout_bcd
);

  logic [4:0] bin_s;

  // Binary sum followed by the +6 decimal correction when it passes 9.
  always_comb begin
    bin_s    = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    s_bcd    = bin_s[3:0];
    cout_bcd = 1'b0;
    if (bin_s > {1'b0, BCD_MAX}) begin
      // 10..19 plus 6 wraps the low nibble onto 0..9
      s_bcd    = bin_s[3:0] + 4'd6;
      cout_bcd = 1'b1;
    end else begin
      s_bcd    = bin_s[3:0];
      cout_bcd = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor producing |A-B| and a sign flag.
// One BCD digit adder is reused: first pass adds A to the 10's complement
// of B, one digit per clock LSB first; if no final carry (A<B) a second pass
// 10's-complements the stored result to recover the magnitude.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of bcd_serial_subtractor_if (start/a/b in,
//          busy/done/diff/neg/invalid out, all outputs registered)
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state_r;
  state_t          state_nx_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    res_r;
  logic [W-1:0]    diff_r;
  logic [CW-1:0]   cnt_r;
  logic            carry_r;
  logic            busy_r;
  logic            done_r;
  logic            neg_r;
  logic            invalid_r;

  logic            any_bad_s;
  logic            last_s;
  logic [3:0]      op_x_s;
  logic [3:0]      op_y_s;
  logic [3:0]      sum_s;
  logic            cout_s;
  logic [W-1:0]    res_nx_s;

  assign last_s   = (cnt_r == LAST_CNT);
  // New digit enters at the top, so after NDIG shifts digit 0 sits at [3:0].
  assign res_nx_s = {sum_s, res_r[W-1:4]};

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.diff    = diff_r;
  assign bus.neg     = neg_r;
  assign bus.invalid = invalid_r;

  // Scan every operand digit for values above 9.
  always_comb begin
    any_bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!digit_ok(bus.a[4*i +: 4]) || !digit_ok(bus.b[4*i +: 4])) begin
        any_bad_s = 1'b1;
      end else begin
        any_bad_s = any_bad_s;
      end
    end
  end

  // Operand mux for the shared adder: A + 9's(B) while subtracting,
  // 0 + 9's(result) while recomplementing.
  always_comb begin
    op_x_s = 4'd0;
    op_y_s = 4'd0;
    if (state_r == ST_SUB) begin
      op_x_s = a_sh_r[3:0];
      op_y_s = nines_comp(b_sh_r[3:0]);
    end else begin
      op_x_s = 4'd0;
      op_y_s = nines_comp(res_r[3:0]);
    end
  end

  bcd_adder_core u_adder (
    .a        (op_x_s),
    .b        (op_y_s),
    .cin      (carry_r),
    .s_bcd    (sum_s),
    .cout_bcd (cout_s)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (any_bad_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_SUB;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (last_s) begin
          if (cout_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RECOMP;
          end
        end else begin
          state_nx_s = ST_SUB;
        end
      end
      ST_RECOMP: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RECOMP;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; results are published only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      res_r     <= '0;
      diff_r    <= '0;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      neg_r     <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b1;
            if (any_bad_s) begin
              invalid_r <= 1'b1;
              diff_r    <= '0;
              neg_r     <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              busy_r <= 1'b1;
            end
          end
        end
        ST_SUB: begin
          a_sh_r  <= {4'd0, a_sh_r[W-1:4]};
          b_sh_r  <= {4'd0, b_sh_r[W-1:4]};
          res_r   <= res_nx_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_s) begin
            cnt_r <= '0;
            if (cout_s) begin
              // no borrow out of the top digit: A >= B, result is the magnitude
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              diff_r    <= res_nx_s;
              neg_r     <= 1'b0;
              invalid_r <= 1'b0;
            end else begin
              // A < B: result holds 10^NDIG - |A-B|, +1 seeds the recomplement
              carry_r <= 1'b1;
            end
          end
        end
        ST_RECOMP: begin
          res_r   <= res_nx_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_s) begin
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            diff_r    <= res_nx_s;
            neg_r     <= 1'b1;
            invalid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
